// File: rtl/pin_beacon_pkg.sv
// Shared types, ASCII constants and the label formatter for the pin identity beacon.
package pin_beacon_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

   localparam logic [7:0] CH_A_BASE = 8'h40;
   localparam logic [7:0] CH_0      = 8'h30;
   localparam logic [7:0] CH_Q      = 8'h3F;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;

   localparam int LETTER_MAX = 26;
   localparam int NUMBER_MAX = 99;

   // bytes[0] goes out first
   typedef struct packed {
      logic [4:0][7:0] bytes;
      logic [2:0]      len;
   } msg_t;

   function automatic msg_t fmt_label(input logic [6:0] letter, input logic [6:0] number);
      msg_t       m;
      logic [6:0] units;
      logic [3:0] tens;
      m       = '0;
      units   = number;
      tens    = '0;
      if (letter == 7'd0 || letter > 7'(LETTER_MAX)) m.bytes[0] = CH_Q;
      else                                            m.bytes[0] = CH_A_BASE + {1'b0, letter};
      // Tens/units by repeated compare-subtract, no divider
      for (int i = 0; i < 9; i++) begin
         if (units >= 7'd10) begin
            units = units - 7'd10;
            tens  = tens + 4'd1;
         end
      end
      if (number > 7'(NUMBER_MAX)) begin
         m.bytes[1] = CH_Q;
         m.bytes[2] = CH_Q;
         m.bytes[3] = CH_CR;
         m.bytes[4] = CH_LF;
         m.len      = 3'd5;
      end else if (number < 7'd10) begin
         m.bytes[1] = CH_0 + {1'b0, units};
         m.bytes[2] = CH_CR;
         m.bytes[3] = CH_LF;
         m.len      = 3'd4;
      end else begin
         m.bytes[1] = CH_0 + {4'b0, tens};
         m.bytes[2] = CH_0 + {1'b0, units};
         m.bytes[3] = CH_CR;
         m.bytes[4] = CH_LF;
         m.len      = 3'd5;
      end
      return m;
   endfunction

endpackage

// File: rtl/pin_beacon_tx_if.sv
// Label inputs and serial/status outputs of the pin beacon, grouped for port connection.
interface pin_beacon_tx_if;
   logic       en;
   logic [6:0] letter;
   logic [6:0] number;
   logic       tx;
   logic       busy;
   logic       msg_done;

   modport master (output en, letter, number, input tx, busy, msg_done);
   modport slave  (input en, letter, number, output tx, busy, msg_done);
endinterface

// File: rtl/pin_beacon_tx_uart_byte_ser.sv
// 8N1 byte serializer: baud counter plus 10-bit frame shifter, one byte accepted per frame.
// line_nxt_o is the value the line takes after the coming edge, so the caller can register it.
module uart_byte_ser #(
   parameter int DIV = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       byte_valid_i,
   input  logic [7:0] byte_dat_i,
   output logic       byte_ready_o,
   output logic       line_nxt_o
);
   localparam int BW = $clog2(DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

   logic [9:0]    shift_q, shift_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic          act_q, act_d;
   logic          rdy;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '1;
         baud_q  <= '0;
         bit_q   <= '0;
         act_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         act_q   <= act_d;
      end
   end

   always_comb begin
      shift_d = shift_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      act_d   = act_q;
      // Ready on the final stop-bit cycle lets the next frame start with no idle gap
      rdy     = !act_q || (bit_q == 4'd9 && baud_q == BAUD_LAST);
      if (act_q) begin
         if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (bit_q == 4'd9) begin
               act_d = 1'b0;
            end else begin
               bit_d   = bit_q + 4'd1;
               shift_d = {1'b1, shift_q[9:1]};
            end
         end else begin
            baud_d = baud_q + BW'(1);
         end
      end
      if (byte_valid_i && rdy) begin
         shift_d = {1'b1, byte_dat_i, 1'b0};
         baud_d  = '0;
         bit_d   = '0;
         act_d   = 1'b1;
      end
      line_nxt_o = act_d ? shift_d[0] : 1'b1;
   end

   assign byte_ready_o = rdy;

endmodule

// File: rtl/pin_beacon_tx.sv
// Pin identity beacon: formats "<letter><number>\r\n" and repeats it as 8N1 UART on one pin.
// Optional PIN_BEACON_INV_EN inverts only the output flop (idle low) for inverting buffers.
module pin_beacon_tx
   import pin_beacon_pkg::*;
#(
   parameter int CLK_FREQ = 25000000,
   parameter int BAUD     = 9600,
   parameter int GAP_BITS = 20
) (
   input  logic            clk_i,
   input  logic            rst_i,
   pin_beacon_tx_if.slave  bus
);
   localparam int DIV     = CLK_FREQ / BAUD;
   localparam int GAP_CYC = GAP_BITS * DIV;
   localparam int GW      = $clog2(GAP_CYC + 1);
`ifdef PIN_BEACON_INV_EN
   localparam logic TX_RST = 1'b0;
`else
   localparam logic TX_RST = 1'b1;
`endif

   state_t        state_q, state_d;
   msg_t          msg_q, msg_d, msg_new;
   logic [2:0]    idx_q, idx_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          tx_q, tx_d;
   logic          byte_vld, byte_rdy, line_nxt, accept, gap_last;
   logic [7:0]    byte_dat;
   logic          busy, msg_done;

   uart_byte_ser #(.DIV(DIV)) u_ser (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byte_valid_i (byte_vld),
      .byte_dat_i   (byte_dat),
      .byte_ready_o (byte_rdy),
      .line_nxt_o   (line_nxt)
   );

   assign msg_new  = fmt_label(bus.letter, bus.number);
   assign accept   = byte_vld && byte_rdy;
   assign gap_last = (gap_q == GW'(GAP_CYC - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.en) state_d = LOAD;
         LOAD: state_d = SEND;
         SEND: if (!byte_vld && byte_rdy) state_d = GAP;
         GAP:  if (gap_last) state_d = bus.en ? LOAD : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      msg_done = (state_q == GAP) && gap_last;
      byte_vld = 1'b0;
      byte_dat = msg_q.bytes[0];
      if (state_q == LOAD) begin
         byte_vld = 1'b1;
         byte_dat = msg_new.bytes[0];
      end else if (state_q == SEND) begin
         byte_vld = (idx_q != msg_q.len);
      end
   end

   // Byte list is held as a shifter so the head byte is always at index 0
   always_comb begin
      msg_d = msg_q;
      idx_d = idx_q;
      gap_d = (state_q == GAP) ? gap_q + GW'(1) : '0;
      if (state_q == LOAD) begin
         msg_d.bytes = {8'h00, msg_new.bytes[4:1]};
         msg_d.len   = msg_new.len;
         idx_d       = 3'd1;
      end else if (state_q == SEND && accept) begin
         msg_d.bytes = {8'h00, msg_q.bytes[4:1]};
         idx_d       = idx_q + 3'd1;
      end
`ifdef PIN_BEACON_INV_EN
      tx_d = ~line_nxt;
`else
      tx_d = line_nxt;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         msg_q <= '0;
         idx_q <= '0;
         gap_q <= '0;
         tx_q  <= TX_RST;
      end else begin
         msg_q <= msg_d;
         idx_q <= idx_d;
         gap_q <= gap_d;
         tx_q  <= tx_d;
      end
   end

   assign bus.tx       = tx_q;
   assign bus.busy     = busy;
   assign bus.msg_done = msg_done;

endmodule

// File: tb/tb_pin_beacon_tx.sv
// Directed bench for pin_beacon_tx with DIV=16, GAP_BITS=4; decodes the UART line and checks timing.
module tb_pin_beacon_tx;
   localparam int DIV      = 16;
   localparam int GAP_BITS = 4;
`ifdef PIN_BEACON_INV_EN
   localparam logic IDLE_LVL = 1'b0;
`else
   localparam logic IDLE_LVL = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_q[$];

   always #5 clk = ~clk;

   pin_beacon_tx_if bus();

   pin_beacon_tx #(.CLK_FREQ(16), .BAUD(1), .GAP_BITS(GAP_BITS)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.msg_done === 1'b1) done_q.push_back(cyc);

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   // Finds the next start bit, samples each bit at its centre; ok=0 on timeout or bad stop bit
   task automatic rx_byte(output logic [7:0] b, output bit ok, output int start_cyc);
      int budget;
      budget = 3000;
      ok = 1'b1;
      b = '0;
      start_cyc = -1;
      while (bus.tx !== ~IDLE_LVL && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) begin
         ok = 1'b0;
         return;
      end
      start_cyc = cyc;
      tick(DIV / 2);
      for (int i = 0; i < 8; i++) begin
         tick(DIV);
         b[i] = (bus.tx === IDLE_LVL);
      end
      tick(DIV);
      if (bus.tx !== IDLE_LVL) ok = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int budget;
      budget = 2000;
      while (bus.busy !== 1'b0 && budget > 0) begin
         tick();
         budget--;
      end
      ok = (budget > 0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.en = 1'b0;
      bus.letter = '0;
      bus.number = '0;
      tick(3);
      checks++;
      if (bus.tx !== IDLE_LVL) begin failures++; $display("FAIL reset_tx got=%b want=%b", bus.tx, IDLE_LVL); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++;
      if (bus.msg_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.msg_done); end
      rst = 1'b0;
      tick(3);
      checks++;
      if (bus.busy !== 1'b0 || bus.tx !== IDLE_LVL) begin
         failures++; $display("FAIL idle_no_en busy=%b tx=%b want busy=0 tx=%b", bus.busy, bus.tx, IDLE_LVL);
      end
   endtask

   task automatic test_single;
      logic [7:0] exp_b[4] = '{8'h4E, 8'h35, 8'h0D, 8'h0A};
      logic [7:0] b;
      bit ok;
      int c, s;
      bus.letter = 7'd14;
      bus.number = 7'd5;
      done_q.delete();
      bus.en = 1'b1;
      c = cyc;
      tick();
      bus.en = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.tx !== IDLE_LVL) begin
         failures++; $display("FAIL single_load busy=%b tx=%b want busy=1 tx=%b", bus.busy, bus.tx, IDLE_LVL);
      end
      tick();
      checks++;
      if (bus.tx !== ~IDLE_LVL) begin failures++; $display("FAIL single_start got=%b want=%b", bus.tx, ~IDLE_LVL); end
      for (int i = 0; i < 4; i++) begin
         rx_byte(b, ok, s);
         checks++;
         if (!ok || b !== exp_b[i]) begin
            failures++; $display("FAIL single_byte%0d got=%h ok=%0d want=%h", i, b, ok, exp_b[i]);
         end
      end
      wait_idle(ok);
      checks++;
      if (!ok || done_q.size() != 1 || done_q[0] != c + 705) begin
         failures++; $display("FAIL single_done count=%0d at=%0d want one pulse at %0d", done_q.size(),
                              (done_q.size() > 0) ? done_q[0] : -1, c + 705);
      end
      tick(3);
      checks++;
      if (bus.busy !== 1'b0 || bus.tx !== IDLE_LVL) begin
         failures++; $display("FAIL single_idle busy=%b tx=%b want busy=0 tx=%b", bus.busy, bus.tx, IDLE_LVL);
      end
   endtask

   task automatic test_repeat;
      logic [7:0] exp_b[5] = '{8'h54, 8'h31, 8'h32, 8'h0D, 8'h0A};
      logic [7:0] b;
      bit ok;
      int c, s, first[2], last1;
      bus.letter = 7'd20;
      bus.number = 7'd12;
      done_q.delete();
      bus.en = 1'b1;
      c = cyc;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 5; i++) begin
            rx_byte(b, ok, s);
            if (i == 0) first[m] = s;
            if (m == 0 && i == 4) last1 = s;
            if (m == 1 && i == 0) bus.en = 1'b0;
            checks++;
            if (!ok || b !== exp_b[i]) begin
               failures++; $display("FAIL repeat_m%0d_byte%0d got=%h ok=%0d want=%h", m, i, b, ok, exp_b[i]);
            end
         end
      end
      checks++;
      if (first[0] != c + 2) begin failures++; $display("FAIL repeat_first_start got=%0d want=%0d", first[0], c + 2); end
      checks++;
      if (first[1] - first[0] != 865) begin
         failures++; $display("FAIL repeat_period got=%0d want=865", first[1] - first[0]);
      end
      // Stop bit of the last byte ends at last1+159; the gap then runs 64 cycles up to msg_done
      checks++;
      if (done_q.size() < 1 || done_q[0] - (last1 + 159) != 64) begin
         failures++; $display("FAIL repeat_gap got=%0d want=64", (done_q.size() > 0) ? done_q[0] - (last1 + 159) : -1);
      end
      wait_idle(ok);
      checks++;
      if (!ok || done_q.size() != 2 || done_q[1] - done_q[0] != 865) begin
         failures++; $display("FAIL repeat_done count=%0d want 2 pulses 865 apart", done_q.size());
      end
   endtask

   task automatic test_unknown;
      logic [7:0] exp_b[5] = '{8'h3F, 8'h3F, 8'h3F, 8'h0D, 8'h0A};
      logic [7:0] b;
      bit ok;
      int s;
      bus.letter = 7'd0;
      bus.number = 7'd100;
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rx_byte(b, ok, s);
         checks++;
         if (!ok || b !== exp_b[i]) begin
            failures++; $display("FAIL unknown_byte%0d got=%h ok=%0d want=%h", i, b, ok, exp_b[i]);
         end
      end
      wait_idle(ok);
   endtask

   task automatic test_mid_change;
      logic [7:0] exp1[4] = '{8'h4E, 8'h35, 8'h0D, 8'h0A};
      logic [7:0] exp2[4] = '{8'h43, 8'h34, 8'h0D, 8'h0A};
      logic [7:0] b;
      bit ok;
      int s;
      bus.letter = 7'd14;
      bus.number = 7'd5;
      bus.en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rx_byte(b, ok, s);
         if (i == 0) begin
            bus.letter = 7'd3;
            bus.number = 7'd4;
         end
         checks++;
         if (!ok || b !== exp1[i]) begin
            failures++; $display("FAIL change_old_byte%0d got=%h ok=%0d want=%h", i, b, ok, exp1[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         rx_byte(b, ok, s);
         if (i == 0) bus.en = 1'b0;
         checks++;
         if (!ok || b !== exp2[i]) begin
            failures++; $display("FAIL change_new_byte%0d got=%h ok=%0d want=%h", i, b, ok, exp2[i]);
         end
      end
      wait_idle(ok);
   endtask

   task automatic test_reset_mid;
      logic [7:0] exp_b[4] = '{8'h4E, 8'h35, 8'h0D, 8'h0A};
      logic [7:0] b;
      bit ok;
      int c, s, s0;
      bus.letter = 7'd14;
      bus.number = 7'd5;
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      rx_byte(b, ok, s0);
      // Centre of data bit 3 (a zero in 0x35) of the second byte
      tick(s0 + 160 + 4 * DIV + DIV / 2 - cyc);
      checks++;
      if (bus.tx !== ~IDLE_LVL) begin failures++; $display("FAIL rstmid_pre got=%b want=%b", bus.tx, ~IDLE_LVL); end
      rst = 1'b1;
      tick();
      checks++;
      if (bus.tx !== IDLE_LVL || bus.busy !== 1'b0 || bus.msg_done !== 1'b0) begin
         failures++; $display("FAIL rstmid_state tx=%b busy=%b done=%b want tx=%b busy=0 done=0",
                              bus.tx, bus.busy, bus.msg_done, IDLE_LVL);
      end
      rst = 1'b0;
      done_q.delete();
      bus.en = 1'b1;
      c = cyc;
      tick();
      bus.en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rx_byte(b, ok, s);
         if (i == 0) begin
            checks++;
            if (s != c + 2) begin failures++; $display("FAIL rstmid_start got=%0d want=%0d", s, c + 2); end
         end
         checks++;
         if (!ok || b !== exp_b[i]) begin
            failures++; $display("FAIL rstmid_byte%0d got=%h ok=%0d want=%h", i, b, ok, exp_b[i]);
         end
      end
      wait_idle(ok);
      checks++;
      if (!ok || done_q.size() != 1 || done_q[0] != c + 705) begin
         failures++; $display("FAIL rstmid_done count=%0d want one pulse at %0d", done_q.size(), c + 705);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_repeat();
      test_unknown();
      test_mid_change();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
